// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-parameter command/readback paths: frame
// header, frame lengths, flag bit positions and the parameter snapshot type.
// The checksum byte is enabled by defining PARAM_TX_CHECKSUM_EN.
package pulse_pkg;

    // First byte of every readback frame.
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Frame lengths in bytes, header included.
    localparam int unsigned FRAME_LEN_BASE = 18;
    localparam int unsigned FRAME_LEN_CSUM = 19;

    // Bit positions of the mode flags inside the flags byte.
    localparam int FLAG_NUTATION = 0;
    localparam int FLAG_PUMP     = 1;
    localparam int FLAG_BLOCK    = 2;

    // Full pulse-sequence configuration, as loaded by the receive-side parser.
    typedef struct packed {
        logic [23:0] period;
        logic [15:0] p1width;
        logic [15:0] delay;
        logic [15:0] p2width;
        logic [15:0] nut_del;
        logic [7:0]  nut_wid;
        logic [7:0]  pulse_block;
        logic [15:0] pulse_block_off;
        logic [7:0]  cpmg;
        logic        nutation;
        logic        pump;
        logic        block;
    } pulse_params_t;

    // Pack the mode flags into their byte; upper bits are zero.
    function automatic logic [7:0] flags_byte(input pulse_params_t p);
        logic [7:0] f;
        f                = 8'h00;
        f[FLAG_NUTATION] = p.nutation;
        f[FLAG_PUMP]     = p.pump;
        f[FLAG_BLOCK]    = p.block;
        return f;
    endfunction

    // Modulo-256 sum of every payload byte (header excluded).
    function automatic logic [7:0] payload_sum(input pulse_params_t p);
        logic [7:0] s;
        s = p.period[23:16] + p.period[15:8] + p.period[7:0]
          + p.p1width[15:8] + p.p1width[7:0]
          + p.delay[15:8] + p.delay[7:0]
          + p.p2width[15:8] + p.p2width[7:0]
          + p.nut_del[15:8] + p.nut_del[7:0]
          + p.nut_wid + p.pulse_block
          + p.pulse_block_off[15:8] + p.pulse_block_off[7:0]
          + p.cpmg + flags_byte(p);
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each
// CLKS_PER_BIT cycles long. A new start is accepted while idle or in the
// last cycle of the stop bit, so bytes can be chained with no idle gap.
// CLKS_PER_BIT must be at least 2 (byte_done is raised one cycle early).
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       byte_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Ready to take a byte: idle, or the stop bit is in its final cycle.
    assign ready = (state == StIdle) || ((state == StStop) && cnt_zero);

    // Raised one cycle before the stop bit ends so the sequencer can present
    // the next byte exactly when the serializer becomes ready again.
    assign byte_done = (state == StStop) && (cnt == CNT_ONE);

    // Bit timing and shifting; tx is registered straight from this FSM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= StIdle;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        shreg <= data;
                        cnt   <= CNT_MAX;
                        tx    <= 1'b0;
                        state <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_zero) begin
                        cnt     <= CNT_MAX;
                        bit_idx <= 3'd0;
                        tx      <= shreg[0];
                        state   <= StData;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StData: begin
                    if (cnt_zero) begin
                        cnt <= CNT_MAX;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= StStop;
                        end else begin
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_zero) begin
                        if (start) begin
                            shreg <= data;
                            cnt   <= CNT_MAX;
                            tx    <= 1'b0;
                            state <= StStart;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/param_readback_tx.sv
// Pulse-parameter readback transmitter. On req it snapshots every pulse
// parameter and sends HEADER followed by the fields (MSB byte first) and the
// flags byte over an 8N1 UART. Define PARAM_TX_CHECKSUM_EN to append a
// checksum byte making the payload sum 0 mod 256.
module param_readback_tx
    import pulse_pkg::*;
#(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 115200,
    parameter logic [7:0]  HEADER = HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [23:0] period,
    input  logic [15:0] p1width,
    input  logic [15:0] delay,
    input  logic [15:0] p2width,
    input  logic [15:0] nut_del,
    input  logic [15:0] pulse_block_off,
    input  logic [7:0]  nut_wid,
    input  logic [7:0]  pulse_block,
    input  logic [7:0]  cpmg,
    input  logic        nutation,
    input  logic        pump,
    input  logic        block,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
`ifdef PARAM_TX_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = FRAME_LEN_CSUM;
`else
    localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWait,
        StFin
    } state_t;

    state_t        state;
    pulse_params_t live;
    pulse_params_t snap;
    logic [4:0]    idx;
    logic [7:0]    tx_byte;
    logic          ser_start;
    logic          ser_ready;
    logic          ser_byte_done;

    // Gather the live inputs into the shared snapshot layout.
    always_comb begin
        live                 = '0;
        live.period          = period;
        live.p1width         = p1width;
        live.delay           = delay;
        live.p2width         = p2width;
        live.nut_del         = nut_del;
        live.nut_wid         = nut_wid;
        live.pulse_block     = pulse_block;
        live.pulse_block_off = pulse_block_off;
        live.cpmg            = cpmg;
        live.nutation        = nutation;
        live.pump            = pump;
        live.block           = block;
    end

    // Select the frame byte for the current index from the snapshot.
    always_comb begin
        tx_byte = HEADER;
        case (idx)
            5'd0:  tx_byte = HEADER;
            5'd1:  tx_byte = snap.period[23:16];
            5'd2:  tx_byte = snap.period[15:8];
            5'd3:  tx_byte = snap.period[7:0];
            5'd4:  tx_byte = snap.p1width[15:8];
            5'd5:  tx_byte = snap.p1width[7:0];
            5'd6:  tx_byte = snap.delay[15:8];
            5'd7:  tx_byte = snap.delay[7:0];
            5'd8:  tx_byte = snap.p2width[15:8];
            5'd9:  tx_byte = snap.p2width[7:0];
            5'd10: tx_byte = snap.nut_del[15:8];
            5'd11: tx_byte = snap.nut_del[7:0];
            5'd12: tx_byte = snap.nut_wid;
            5'd13: tx_byte = snap.pulse_block;
            5'd14: tx_byte = snap.pulse_block_off[15:8];
            5'd15: tx_byte = snap.pulse_block_off[7:0];
            5'd16: tx_byte = snap.cpmg;
            5'd17: tx_byte = flags_byte(snap);
`ifdef PARAM_TX_CHECKSUM_EN
            5'd18: tx_byte = 8'h00 - payload_sum(snap);
`endif
            default: tx_byte = HEADER;
        endcase
    end

    // The serializer takes the byte in the SEND cycle.
    assign ser_start = (state == StSend);

    // Frame sequencer: snapshot, hand bytes over one by one, then pulse done.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= StIdle;
            snap  <= '0;
            idx   <= 5'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req) begin
                        busy  <= 1'b1;
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    snap  <= live;
                    idx   <= 5'd0;
                    state <= StSend;
                end
                StSend: begin
                    if (ser_ready) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (ser_byte_done) begin
                        if (idx == LAST_IDX) begin
                            state <= StFin;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= StSend;
                        end
                    end
                end
                StFin: begin
                    // Stop bit of the last byte is in its final cycle here.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk      (clk),
        .resetn   (resetn),
        .start    (ser_start),
        .data     (tx_byte),
        .tx       (tx),
        .ready    (ser_ready),
        .byte_done(ser_byte_done)
    );

endmodule

// File: tb/tb_param_readback_tx.sv
// Self-checking bench for param_readback_tx. A UART monitor decodes tx and
// compares each byte against a scoreboard filled when req is driven.
// Builds with or without PARAM_TX_CHECKSUM_EN.
module tb_param_readback_tx;

    localparam int unsigned CLK_HZ = 12000000;
    // Shorter bit time than the default baud keeps the run short.
    localparam int unsigned BAUD   = 500000;
    localparam int unsigned BIT    = CLK_HZ / BAUD;
`ifdef PARAM_TX_CHECKSUM_EN
    localparam int unsigned FL = 19;
`else
    localparam int unsigned FL = 18;
`endif
    localparam int unsigned FRAME_CYC = FL * 10 * BIT;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic [23:0] period;
    logic [15:0] p1width, delay, p2width, nut_del, pulse_block_off;
    logic [7:0]  nut_wid, pulse_block, cpmg;
    logic        nutation, pump, block;
    logic        tx, busy, done;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int fall_cnt = 0;
    int busy_seq = 0;
    int rst_epoch = 0;
    logic busy_prev = 1'b0;
    logic [8:0] exp_q[$];

    param_readback_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .HEADER(8'hA5)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .req            (req),
        .period         (period),
        .p1width        (p1width),
        .delay          (delay),
        .p2width        (p2width),
        .nut_del        (nut_del),
        .pulse_block_off(pulse_block_off),
        .nut_wid        (nut_wid),
        .pulse_block    (pulse_block),
        .cpmg           (cpmg),
        .nutation       (nutation),
        .pump           (pump),
        .block          (block),
        .tx             (tx),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (busy_prev && !busy) fall_cnt <= fall_cnt + 1;
        if (!busy_prev && busy) busy_seq <= busy_seq + 1;
        busy_prev <= busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_defaults();
        period = 24'h010000; p1width = 16'd30; delay = 16'd200; p2width = 16'd60;
        nut_del = 16'd100; nut_wid = 8'd100; pulse_block = 8'd50;
        pulse_block_off = 16'd100; cpmg = 8'd1;
        nutation = 1'b1; pump = 1'b1; block = 1'b1;
    endtask

    // Reference frame built from the bench's own copy of the inputs.
    task automatic push_frame();
        logic [7:0] b[18];
        logic [7:0] sum;
        b = '{8'hA5, period[23:16], period[15:8], period[7:0],
              p1width[15:8], p1width[7:0], delay[15:8], delay[7:0],
              p2width[15:8], p2width[7:0], nut_del[15:8], nut_del[7:0],
              nut_wid, pulse_block, pulse_block_off[15:8], pulse_block_off[7:0],
              cpmg, {5'b0, block, pump, nutation}};
        sum = 8'h00;
        for (int i = 0; i < 18; i++) begin
            exp_q.push_back({1'b0, b[i]});
            if (i > 0) sum = sum + b[i];
        end
`ifdef PARAM_TX_CHECKSUM_EN
        exp_q.push_back({1'b0, 8'h00 - sum});
`endif
    endtask

    task automatic pulse_req();
        @(negedge clk) req = 1'b1;
        @(negedge clk) req = 1'b0;
    endtask

    task automatic wait_busy_rise(output int t);
        int k;
        k = 0;
        while (busy !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("busy_rise", busy, 1);
        t = cyc;
    endtask

    task automatic wait_done(output int t);
        int k;
        k = 0;
        while (done !== 1'b1 && k < FRAME_CYC + 200) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done, 1);
        t = cyc;
    endtask

    // UART monitor: decode every byte on tx and pop the scoreboard.
    initial begin
        int st, prev_start, prev_seq, ep;
        logic [7:0] d;
        logic stop_bit;
        logic [8:0] expv;
        bit have_prev;
        have_prev = 1'b0;
        prev_start = 0;
        prev_seq = 0;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && tx === 1'b0) begin
                st = cyc;
                ep = rst_epoch;
                if (busy && have_prev && prev_seq == busy_seq)
                    chk("byte_spacing", st - prev_start, 10 * BIT);
                have_prev = 1'b1;
                prev_start = st;
                prev_seq = busy_seq;
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    d[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                stop_bit = tx;
                if (ep == rst_epoch) begin
                    chk("stop_bit", stop_bit, 1);
                    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                    chk("rx_byte", {1'b0, d}, expv);
                end else begin
                    have_prev = 1'b0;
                end
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int tb_t, td_t, k, lows, d0, f0;
        set_defaults();
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_tx_before", tx, 1);

        // Default frame: latency, duration, done shape, idle after.
        push_frame();
        pulse_req();
        wait_busy_rise(tb_t);
        k = 0;
        while (tx === 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("start_latency_le2", (k <= 2) && (tx === 1'b0), 1);
        wait_done(td_t);
        chk("frame_duration", (td_t - tb_t >= FRAME_CYC) && (td_t - tb_t <= FRAME_CYC + 2), 1);
        chk("busy_low_with_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        lows = 0;
        for (int i = 0; i < 3 * BIT; i++) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
        chk("idle_tx_after", lows, 0);
        chk("frame1_drained", exp_q.size(), 0);

        // Input change during the 3rd byte must not reach the frame in flight.
        push_frame();
        pulse_req();
        wait_busy_rise(tb_t);
        repeat (2 + 2 * 10 * BIT + 3 * BIT) @(negedge clk);
        period = 24'hFFFFFF;
        wait_done(td_t);
        repeat (BIT) @(negedge clk);
        push_frame();
        pulse_req();
        wait_busy_rise(tb_t);
        wait_done(td_t);
        repeat (BIT) @(negedge clk);
        chk("snapshot_frames_drained", exp_q.size(), 0);
        set_defaults();

        // req during byte 5 is ignored.
        push_frame();
        d0 = done_cnt;
        f0 = fall_cnt;
        pulse_req();
        wait_busy_rise(tb_t);
        repeat (2 + 4 * 10 * BIT + 3 * BIT) @(negedge clk);
        pulse_req();
        wait_done(td_t);
        repeat (20 * BIT) @(negedge clk);
        chk("single_done", done_cnt - d0, 1);
        chk("single_busy_fall", fall_cnt - f0, 1);
        chk("no_extra_frame_busy", busy, 0);
        chk("no_extra_frame_drained", exp_q.size(), 0);

        // Reset for one cycle during byte 9 abandons the frame.
        push_frame();
        pulse_req();
        wait_busy_rise(tb_t);
        repeat (2 + 8 * 10 * BIT + 4 * BIT) @(negedge clk);
        rst_epoch++;
        exp_q.delete();
        d0 = done_cnt;
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset_tx", tx, 1);
        chk("midreset_busy", busy, 0);
        resetn = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        chk("midreset_no_done", done_cnt - d0, 0);
        period = 24'($urandom);
        p1width = 16'($urandom);
        delay = 16'($urandom);
        p2width = 16'($urandom);
        nut_del = 16'($urandom);
        nut_wid = 8'($urandom);
        pulse_block = 8'($urandom);
        pulse_block_off = 16'($urandom);
        cpmg = 8'($urandom);
        nutation = 1'b0; pump = 1'b1; block = 1'b0;
        push_frame();
        pulse_req();
        wait_busy_rise(tb_t);
        wait_done(td_t);
        repeat (BIT) @(negedge clk);
        chk("post_reset_frame_drained", exp_q.size(), 0);
        set_defaults();

        // req held high re-triggers right after FIN.
        push_frame();
        push_frame();
        @(negedge clk) req = 1'b1;
        wait_busy_rise(tb_t);
        wait_done(td_t);
        @(negedge clk);
        chk("retrigger_busy", busy, 1);
        req = 1'b0;
        wait_done(td_t);
        repeat (20 * BIT) @(negedge clk);
        chk("retrigger_idle", busy, 0);
        chk("retrigger_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
